// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the arbiter and the register file write port.
interface regfile_wb_arbiter_if;
  logic        a_valid_i;
  logic        a_ready_o;
  logic [4:0]  a_rd_addr_i;
  logic [31:0] a_rd_data_i;
  logic        b_valid_i;
  logic        b_ready_o;
  logic [4:0]  b_rd_addr_i;
  logic [31:0] b_rd_data_i;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        wb_src_o;

  // Arbiter side.
  modport slave (
    input  a_valid_i, a_rd_addr_i, a_rd_data_i,
    input  b_valid_i, b_rd_addr_i, b_rd_data_i,
    output a_ready_o, b_ready_o,
    output rd_we_o, rd_addr_o, rd_data_o, wb_src_o
  );

  // Requester / register file side.
  modport master (
    output a_valid_i, a_rd_addr_i, a_rd_data_i,
    output b_valid_i, b_rd_addr_i, b_rd_data_i,
    input  a_ready_o, b_ready_o,
    input  rd_we_o, rd_addr_o, rd_data_o, wb_src_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: port A (ALU/LSU) has fixed priority, port B (MUL/DIV)
// is forced through after STARVE_LIMIT consecutive blocked cycles. Write port is registered.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             starve;
  logic             a_ready;
  logic             b_ready;
  logic             a_xfer;
  logic             b_xfer;
  logic             rd_we;
  logic [4:0]       rd_addr;
  logic [31:0]      rd_data;
  logic             wb_src;

  // Grant decision from the current valids and starvation state; at most one transfer per cycle.
  always_comb begin
    starve  = (wait_cnt >= CNT_W'(STARVE_LIMIT));
    a_ready = !(bus.b_valid_i && starve);
    b_ready = bus.b_valid_i && (!bus.a_valid_i || starve);
    a_xfer  = bus.a_valid_i && a_ready;
    b_xfer  = b_ready;
  end

  // Registered write port; a write to x0 is accepted but never enabled.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_we   <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
      wb_src  <= 1'b0;
    end else if (b_xfer) begin
      rd_we   <= (bus.b_rd_addr_i != 5'd0);
      rd_addr <= bus.b_rd_addr_i;
      rd_data <= bus.b_rd_data_i;
      wb_src  <= 1'b1;
    end else if (a_xfer) begin
      rd_we   <= (bus.a_rd_addr_i != 5'd0);
      rd_addr <= bus.a_rd_addr_i;
      rd_data <= bus.a_rd_data_i;
      wb_src  <= 1'b0;
    end else begin
      rd_we   <= 1'b0;
    end
  end

  // Counts consecutive cycles B is refused; saturates, clears when B transfers or withdraws.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wait_cnt <= '0;
    end else if (!bus.b_valid_i || b_xfer) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign bus.a_ready_o = a_ready;
  assign bus.b_ready_o = b_ready;
  assign bus.rd_we_o   = rd_we;
  assign bus.rd_addr_o = rd_addr;
  assign bus.rd_data_o = rd_data;
  assign bus.wb_src_o  = wb_src;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: literal checks per scenario plus a
// per-cycle reference model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid_i   = 1'b0;
    bus.b_valid_i   = 1'b0;
    bus.a_rd_addr_i = '0;
    bus.a_rd_data_i = '0;
    bus.b_rd_addr_i = '0;
    bus.b_rd_data_i = '0;
  endtask

  // Reference model: B is refused while A requests, unless B has already been
  // refused LIMIT cycles in a row. Whatever is granted shows up one cycle later.
  int          refused;
  bit          started;
  bit          exp_we;
  bit          known;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  bit          exp_src;

  initial begin
    refused = 0;
    started = 0;
    exp_we  = 0;
    known   = 0;
  end

  // Compare on the falling edge, then predict the effect of the coming rising edge.
  always @(negedge clk) begin
    bit b_wins;
    bit a_ok;
    bit starved;
    starved = (refused >= int'(LIMIT));
    b_wins  = bus.b_valid_i && (!bus.a_valid_i || starved);
    a_ok    = !(bus.b_valid_i && starved);
    if (started) begin
      check("model rd_we", 32'(bus.rd_we_o), 32'(exp_we));
      if (exp_we || known) begin
        check("model rd_addr", 32'(bus.rd_addr_o), 32'(exp_addr));
        check("model rd_data", bus.rd_data_o, exp_data);
        check("model wb_src", 32'(bus.wb_src_o), 32'(exp_src));
      end
      check("model a_ready", 32'(bus.a_ready_o), 32'(a_ok));
      check("model b_ready", 32'(bus.b_ready_o), 32'(b_wins));
    end
    if (!rst_n) begin
      started  = 1;
      exp_we   = 0;
      exp_addr = '0;
      exp_data = '0;
      exp_src  = 0;
      known    = 1;
      refused  = 0;
    end else if (started) begin
      if (b_wins) begin
        exp_we   = (bus.b_rd_addr_i != 0);
        exp_addr = bus.b_rd_addr_i;
        exp_data = bus.b_rd_data_i;
        exp_src  = 1;
        known    = exp_we;
        refused  = 0;
      end else begin
        if (bus.a_valid_i) begin
          exp_we   = (bus.a_rd_addr_i != 0);
          exp_addr = bus.a_rd_addr_i;
          exp_data = bus.a_rd_data_i;
          exp_src  = 0;
          known    = exp_we;
        end else begin
          exp_we = 0;
        end
        refused = bus.b_valid_i ? refused + 1 : 0;
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();

    // Reset held for three edges with both requesters active.
    rst_n           = 1'b0;
    bus.a_valid_i   = 1'b1;
    bus.a_rd_addr_i = 5'd3;
    bus.a_rd_data_i = 32'h0000_0033;
    bus.b_valid_i   = 1'b1;
    bus.b_rd_addr_i = 5'd4;
    bus.b_rd_data_i = 32'h0000_0044;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset rd_we", 32'(bus.rd_we_o), 32'd0);
      check("reset wait_cnt", 32'(dut.wait_cnt), 32'd0);
    end
    check("reset rd_addr", 32'(bus.rd_addr_o), 32'd0);
    check("reset rd_data", bus.rd_data_o, 32'd0);
    rst_n = 1'b1;
    tick();
    check("first grant we", 32'(bus.rd_we_o), 32'd1);
    check("first grant src", 32'(bus.wb_src_o), 32'd0);
    check("first grant addr", 32'(bus.rd_addr_o), 32'd3);
    idle_inputs();
    tick();

    // A only.
    bus.a_valid_i   = 1'b1;
    bus.a_rd_addr_i = 5'd5;
    bus.a_rd_data_i = 32'hDEAD_BEEF;
    #1;
    check("A only a_ready", 32'(bus.a_ready_o), 32'd1);
    tick();
    idle_inputs();
    check("A only rd_we", 32'(bus.rd_we_o), 32'd1);
    check("A only rd_addr", 32'(bus.rd_addr_o), 32'd5);
    check("A only rd_data", bus.rd_data_o, 32'hDEAD_BEEF);
    check("A only wb_src", 32'(bus.wb_src_o), 32'd0);

    // B only.
    bus.b_valid_i   = 1'b1;
    bus.b_rd_addr_i = 5'd31;
    bus.b_rd_data_i = 32'h1234_5678;
    #1;
    check("B only b_ready", 32'(bus.b_ready_o), 32'd1);
    tick();
    idle_inputs();
    check("B only rd_we", 32'(bus.rd_we_o), 32'd1);
    check("B only rd_addr", 32'(bus.rd_addr_o), 32'd31);
    check("B only rd_data", bus.rd_data_o, 32'h1234_5678);
    check("B only wb_src", 32'(bus.wb_src_o), 32'd1);

    // Starvation: both held, B forced through every fifth cycle.
    bus.a_valid_i   = 1'b1;
    bus.a_rd_addr_i = 5'd1;
    bus.a_rd_data_i = 32'hAAAA_0000;
    bus.b_valid_i   = 1'b1;
    bus.b_rd_addr_i = 5'd2;
    bus.b_rd_data_i = 32'hBBBB_0000;
    for (int k = 0; k < 15; k++) begin
      #1;
      check("starve a_ready", 32'(bus.a_ready_o), 32'((k % 5) != 4));
      check("starve b_ready", 32'(bus.b_ready_o), 32'((k % 5) == 4));
      tick();
      check("starve rd_we", 32'(bus.rd_we_o), 32'd1);
      check("starve wb_src", 32'(bus.wb_src_o), 32'((k % 5) == 4));
      check("starve rd_data", bus.rd_data_o, ((k % 5) == 4) ? 32'hBBBB_0000 : 32'hAAAA_0000);
    end
    idle_inputs();
    tick();
    check("idle rd_we", 32'(bus.rd_we_o), 32'd0);
    check("idle hold addr", 32'(bus.rd_addr_o), 32'd2);
    check("idle hold data", bus.rd_data_o, 32'hBBBB_0000);
    check("idle hold src", 32'(bus.wb_src_o), 32'd1);

    // Write to x0 is accepted but not enabled.
    bus.a_valid_i   = 1'b1;
    bus.a_rd_addr_i = 5'd0;
    bus.a_rd_data_i = 32'hFFFF_FFFF;
    #1;
    check("x0 a_ready", 32'(bus.a_ready_o), 32'd1);
    tick();
    idle_inputs();
    check("x0 rd_we", 32'(bus.rd_we_o), 32'd0);

    // B transfer presented in the same cycle reset is sampled: it must be dropped.
    bus.b_valid_i   = 1'b1;
    bus.b_rd_addr_i = 5'd7;
    bus.b_rd_data_i = 32'h0000_0077;
    rst_n           = 1'b0;
    #1;
    check("rst mid b_ready", 32'(bus.b_ready_o), 32'd1);
    tick();
    idle_inputs();
    check("rst mid rd_we N+1", 32'(bus.rd_we_o), 32'd0);
    tick();
    check("rst mid rd_we N+2", 32'(bus.rd_we_o), 32'd0);
    check("rst mid wait_cnt", 32'(dut.wait_cnt), 32'd0);
    check("rst mid rd_addr", 32'(bus.rd_addr_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // B refused twice, then A withdraws: B goes through and the counter clears.
    bus.a_valid_i   = 1'b1;
    bus.a_rd_addr_i = 5'd9;
    bus.a_rd_data_i = 32'h0000_0009;
    bus.b_valid_i   = 1'b1;
    bus.b_rd_addr_i = 5'd10;
    bus.b_rd_data_i = 32'h0000_000A;
    tick();
    tick();
    check("partial wait_cnt", 32'(dut.wait_cnt), 32'd2);
    bus.a_valid_i = 1'b0;
    #1;
    check("A drop b_ready", 32'(bus.b_ready_o), 32'd1);
    tick();
    idle_inputs();
    check("A drop wb_src", 32'(bus.wb_src_o), 32'd1);
    check("A drop rd_data", bus.rd_data_o, 32'h0000_000A);
    check("A drop wait_cnt", 32'(dut.wait_cnt), 32'd0);
    tick();
    tick();
    #6;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
